bcd_to_bin_seq: RTL and testbench

- Sequential BCD-to-binary converter using reverse double-dabble (shift-right, subtract-3 on each digit ≥ 8). It is the inverse path of the board's binary-to-BCD display chain.
- Takes NDIG packed BCD digits, for example entered on SW, and returns the unsigned binary value.
- Used wherever decimal entry must feed arithmetic logic. Start/busy/done handshake; one conversion in flight.

---
 rtl/bcd_to_bin_seq_pkg.sv | 20 ++
 rtl/bcd_to_bin_seq_if.sv | 15 +
 rtl/bcd_to_bin_seq_digit_adjust.sv | 9 +
 rtl/bcd_to_bin_seq.sv | 99 +++++++++
 tb/tb_bcd_to_bin_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Optional build macro: BCD_DIGIT_CHECK_EN (see bcd_to_bin_seq).
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT  = 4'd9;
  localparam bcd_digit_t DDABBLE_THRESH = 4'd8;
  localparam bcd_digit_t DDABBLE_ADJ    = 4'd3;

  // ceil(log2(10^ndig)): bits needed for the largest NDIG-digit decimal value
  function automatic int bin_w(input int ndig);
    int p;
    p = 1;
    for (int i = 0; i < ndig; i++) p = p * 10;
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Start/busy/done handshake bundle between a requester and bcd_to_bin_seq.
interface bcd_to_bin_seq_if #(parameter int NDIG = 3);
  import bcd_pkg::*;
  localparam int BIN_W = bin_w(NDIG);

  logic             start;
  logic [4*NDIG-1:0] bcd_in;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] bin_out;
  logic             err;

  modport master (output start, bcd_in, input busy, done, bin_out, err);
  modport slave  (input start, bcd_in, output busy, done, bin_out, err);
endinterface

// File: rtl/bcd_to_bin_seq_digit_adjust.sv
// Reverse double-dabble digit correction: subtract 3 from a digit >= 8.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);
  assign dout = (din >= DDABBLE_THRESH) ? bcd_digit_t'(din - DDABBLE_ADJ) : din;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Build macro BCD_DIGIT_CHECK_EN enables invalid-digit detection on err.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIG = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_to_bin_seq_if.slave  bus
);
  localparam int BIN_W = bin_w(NDIG);
  localparam int HALF  = 4*NDIG;
  localparam int SR_W  = 8*NDIG;
  localparam int CNT_W = $clog2(HALF+1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF-1);

  state_t           state, state_nx;
  logic [SR_W-1:0]  sr, sr_sh, sr_adj;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] bin_q;
  logic             accept, last;

  // upper half: BCD field being drained; lower half: binary field being filled
  assign sr_sh = sr >> 1;
  assign sr_adj[HALF-1:0] = sr_sh[HALF-1:0];

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (sr_sh [HALF+4*g +: 4]),
      .dout (sr_adj[HALF+4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE:  if (bus.start) begin accept = 1'b1; state_nx = SHIFT; end
      SHIFT: if (cnt == LAST) begin last = 1'b1; state_nx = DONE; end
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy    = (state == SHIFT);
  assign bus.done    = (state == DONE);
  assign bus.bin_out = bin_q;

`ifdef BCD_DIGIT_CHECK_EN
  logic bad_in, bad_q, err_q;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (bus.bcd_in[4*i +: 4] > BCD_MAX_DIGIT) bad_in = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      bad_q <= bad_in;
    end else if (last) begin
      err_q <= bad_q;
    end
  end

  assign bus.err = err_q;
`else
  logic bad_q;
  assign bad_q   = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      cnt   <= '0;
      bin_q <= '0;
    end else if (accept) begin
      sr  <= {bus.bcd_in, {HALF{1'b0}}};
      cnt <= '0;
    end else if (state == SHIFT) begin
      sr  <= sr_adj;
      cnt <= cnt + 1'b1;
      // flagged inputs report zero rather than a meaningless conversion
      if (last) bin_q <= bad_q ? '0 : sr_adj[BIN_W-1:0];
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq (NDIG=3): driver pushes expectations,
// monitor pops and checks value, err, latency, busy span and done width.
module tb_bcd_to_bin_seq;
  localparam int NDIG = 3;
  localparam int LAT  = 4*NDIG;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_to_bin_seq_if #(.NDIG(NDIG)) bus ();

  bcd_to_bin_seq #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int val;
    bit err;
    bit chk_val;
    int acc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // decimal meaning of the packed digits, straight from place values
  function automatic exp_t model(input int x, input int acc);
    exp_t e;
    int d, v, w;
    bit bad;
    v = 0; w = 1; bad = 0;
    for (int i = 0; i < NDIG; i++) begin
      d = (x >> (4*i)) & 15;
      if (d > 9) bad = 1;
      v = v + d*w;
      w = w * 10;
    end
    e.acc = acc;
`ifdef BCD_DIGIT_CHECK_EN
    e.val = bad ? 0 : v;
    e.err = bad;
    e.chk_val = 1;
`else
    e.val = v;
    e.err = 0;
    e.chk_val = !bad;
`endif
    return e;
  endfunction

  function automatic int to_bcd(input int v);
    int r;
    r = 0;
    for (int i = 0; i < NDIG; i++) begin
      r = r | ((v % 10) << (4*i));
      v = v / 10;
    end
    return r;
  endfunction

  // monitor
  int  brun = 0;
  bit  prev_done = 0;
  initial begin
    exp_t e;
    forever @(negedge clk) begin
      if (rst_n === 1'b1) begin
        if (bus.done) begin
          chk("busy_during_done", int'(bus.busy), 0);
          chk("done_width", int'(prev_done), 0);
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done: got done=1, expected no pending conversion (cycle %0d)", cyc);
          end else begin
            e = q.pop_front();
            if (e.chk_val) chk("bin_out", int'(bus.bin_out), e.val);
            chk("err", int'(bus.err), int'(e.err));
            chk("latency", cyc - e.acc, LAT);
            chk("busy_span", brun, LAT);
          end
        end
        if (bus.busy) brun++; else brun = 0;
        prev_done = bus.done;
      end else begin
        brun = 0;
        prev_done = 0;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || bus.done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  task automatic conv(input int x);
    wait_idle();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 12'(x);
    q.push_back(model(x, cyc + 1));
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bcd_in = 12'($urandom);
  endtask

  initial begin
    int c, n;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.bcd_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_bin_out", int'(bus.bin_out), 0);
    chk("rst_err", int'(bus.err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    conv('h999);
    conv('h000);
    conv('h100);
    conv('h255);
    conv('h1A3);
    conv('h123);

    // start held high: accepted only from IDLE, bcd_in wiggled mid-conversion
    wait_idle();
    @(negedge clk);
    c = cyc;
    bus.start  = 1'b1;
    bus.bcd_in = 12'h042;
    q.push_back(model('h042, c + 1));
    q.push_back(model('h042, c + 1 + LAT + 2));
    q.push_back(model('h042, c + 1 + 2*(LAT + 2)));
    for (int k = 1; k <= 2*(LAT+2)+1; k++) begin
      @(negedge clk);
      if (k == 4 || k == 18) bus.bcd_in = 12'h999;
      if (k == 11 || k == 25) bus.bcd_in = 12'h042;
    end
    bus.start = 1'b0;

    // reset mid-conversion: asynchronous clear, no done pulse afterwards
    wait_idle();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 12'h777;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_bin_out", int'(bus.bin_out), 0);
    chk("abort_err", int'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    conv('h777);

    for (int v = 0; v < 1000; v++) conv(to_bcd(v));
    for (int i = 0; i < 100; i++) conv(int'($urandom_range(0, 4095)));

    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) chk("drain_pending", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
